icache_ro: RTL and testbench

Read-only, direct-mapped instruction cache. It is the responder on the ICACHE interface driven by the IF stage, and it refills from main memory over a 128-bit block interface. Hits return the word combinationally in the same cycle with no stall. Misses hold `proc_stall` high while one 4-word block is fetched, then serve the request from the cache.

---
 rtl/icache_ro.sv | 133 +++++++++++++
 tb/tb_icache_ro.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ro.sv
// icache_ro: read-only direct-mapped instruction cache with one 4-word
// block per line. Hits are answered combinationally in the request cycle;
// a miss stalls the requester while one 128-bit block is fetched and then
// installed at the indexed line.
module icache_ro #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_READMEM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [127:0]          r_data [NUM_BLOCKS];

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic                  w_stall;
  logic                  w_mread;
  logic                  w_fill;
  logic [31:0]           w_word;
  logic                  w_unused;

  // Write-side request inputs have no effect on a read-only cache.
  assign w_unused = ^{proc_write, proc_wdata};

  assign w_idx  = proc_addr[IDX_W+1:2];
  assign w_tag  = proc_addr[29:IDX_W+2];
  assign w_line = r_data[w_idx];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Select the requested word of the indexed line (driven even on a miss).
  always_comb begin
    w_word = w_line[31:0];
    case (proc_addr[1:0])
      2'd0:    w_word = w_line[31:0];
      2'd1:    w_word = w_line[63:32];
      2'd2:    w_word = w_line[95:64];
      2'd3:    w_word = w_line[127:96];
      default: w_word = w_line[31:0];
    endcase
  end

  // Next-state and stall/request decode for the IDLE/READMEM controller.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_mread = 1'b0;
    w_fill  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (proc_read && !w_hit) begin
          w_stall = 1'b1;
          w_next  = S_READMEM;
        end else begin
          w_stall = 1'b0;
          w_next  = S_IDLE;
        end
      end
      S_READMEM: begin
        w_stall = 1'b1;
        w_mread = 1'b1;
        if (mem_ready) begin
          w_fill = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_READMEM;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Controller state register; reset abandons any outstanding fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Valid bits: cleared by reset, set when a refill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: overwritten unconditionally on refill, never reset.
  always_ff @(posedge clk) begin
    if (w_fill && rst_n) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_rdata;
    end
  end

  assign proc_stall = w_stall;
  assign proc_rdata = w_word;
  assign mem_read   = w_mread;
  assign mem_addr   = proc_addr[29:2];
  assign mem_write  = 1'b0;
  assign mem_wdata  = 128'd0;

endmodule

// File: tb/tb_icache_ro.sv
// Directed bench for icache_ro: a table of hit/idle vectors plus
// hand-written miss, conflict, back-to-back, spurious-input and
// reset-during-refill sequences.
module tb_icache_ro;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic [127:0] mem_wdata;
  logic         mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] BLK_A = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] BLK_B = 128'hB0000004_B0000003_B0000002_B0000001;
  localparam logic [127:0] BLK_C = 128'hC0000004_C0000003_C0000002_C0000001;
  localparam logic [127:0] BLK_D = 128'hD0000004_D0000003_D0000002_D0000001;
  localparam logic [127:0] BLK_E = 128'hE0000004_E0000003_E0000002_E0000001;
  localparam logic [127:0] BLK_F = 128'hF0000004_F0000003_F0000002_F0000001;
  localparam logic [127:0] BLK_G = 128'h90000004_90000003_90000002_90000001;

  icache_ro #(.NUM_BLOCKS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
    logic        chk_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] w);
    logic [127:0] b;
    b = blk;
    return b[w*32 +: 32];
  endfunction

  // Caller has already presented a missing address in IDLE this cycle.
  task automatic miss_seq(input string nm, input logic [29:0] addr, input int k,
                          input logic [127:0] blk);
    int stalls;
    #1;
    chk({nm, "_c0_stall"}, proc_stall, 1'b1);
    chk({nm, "_c0_mread"}, mem_read, 1'b0);
    stalls = 1;
    for (int i = 1; i <= k; i++) begin
      tick();
      #1;
      chk({nm, "_rm_mread"}, mem_read, 1'b1);
      chk({nm, "_rm_stall"}, proc_stall, 1'b1);
      chk({nm, "_rm_maddr"}, mem_addr, addr[29:2]);
      if (proc_stall) stalls++;
      if (i == k) begin
        mem_ready = 1'b1;
        mem_rdata = blk;
      end
    end
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk({nm, "_done_stall"}, proc_stall, 1'b0);
    chk({nm, "_done_mread"}, mem_read, 1'b0);
    chk({nm, "_done_rdata"}, proc_rdata, word_of(blk, addr[1:0]));
    chk({nm, "_stall_cycles"}, stalls, k + 1);
  endtask

  vec_t vecs[8];
  int   low;

  initial begin
    vecs[0] = '{"hit_w1",      1'b1, 1'b0, 30'h1,  32'h0,        1'b0, 32'h2, 1'b1};
    vecs[1] = '{"hit_w2",      1'b1, 1'b0, 30'h2,  32'h0,        1'b0, 32'h3, 1'b1};
    vecs[2] = '{"hit_w3",      1'b1, 1'b0, 30'h3,  32'h0,        1'b0, 32'h4, 1'b1};
    vecs[3] = '{"hit_w0",      1'b1, 1'b0, 30'h0,  32'h0,        1'b0, 32'h1, 1'b1};
    vecs[4] = '{"idle_nored",  1'b0, 1'b0, 30'h44, 32'h0,        1'b0, 32'h0, 1'b0};
    vecs[5] = '{"hit_with_wr", 1'b1, 1'b1, 30'h2,  32'hFFFFFFFF, 1'b0, 32'h3, 1'b1};
    vecs[6] = '{"wr_only",     1'b0, 1'b1, 30'h50, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0};
    vecs[7] = '{"hit_w3_again",1'b1, 1'b0, 30'h3,  32'h0,        1'b0, 32'h4, 1'b1};

    rst_n      = 1'b0;
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = 30'h25;
    proc_wdata = 32'h0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;

    // Reset state: every access misses, mem_addr tracks the address.
    tick();
    #1;
    chk("rst_stall",  proc_stall, 1'b1);
    chk("rst_mread",  mem_read, 1'b0);
    chk("rst_maddr",  mem_addr, 28'h9);
    chk("rst_mwrite", mem_write, 1'b0);
    chk("rst_mwdata", mem_wdata, 128'd0);
    proc_read = 1'b0;
    #1;
    chk("rst_noread_stall", proc_stall, 1'b0);

    // Cold miss at address 0, memory latency 3.
    tick();
    rst_n     = 1'b1;
    tick();
    proc_read = 1'b1;
    proc_addr = 30'h0;
    miss_seq("cold", 30'h0, 3, BLK_A);

    // Table of hit and idle vectors on line 0.
    foreach (vecs[i]) begin
      tick();
      proc_read  = vecs[i].rd;
      proc_write = vecs[i].wr;
      proc_addr  = vecs[i].addr;
      proc_wdata = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_stall"}, proc_stall, vecs[i].exp_stall);
      chk({vecs[i].name, "_mread"}, mem_read, 1'b0);
      chk({vecs[i].name, "_mwrite"}, mem_write, 1'b0);
      if (vecs[i].chk_rdata) chk({vecs[i].name, "_rdata"}, proc_rdata, vecs[i].exp_rdata);
    end
    proc_write = 1'b0;
    proc_wdata = 32'h0;

    // Conflict miss on index 0, then the evicted block misses again.
    tick();
    proc_read = 1'b1;
    proc_addr = 30'h20;
    #1;
    chk("conf_maddr", mem_addr, 28'h8);
    miss_seq("conf", 30'h20, 2, BLK_B);
    tick();
    proc_addr = 30'h0;
    miss_seq("refill0", 30'h0, 1, BLK_A);

    // Back-to-back misses with latency 1: next address presented right after refill.
    tick();
    proc_addr = 30'h4;
    #1;
    chk("b2b_first_stall", proc_stall, 1'b1);
    tick();
    #1;
    chk("b2b_first_mread", mem_read, 1'b1);
    chk("b2b_first_maddr", mem_addr, 28'h1);
    mem_ready = 1'b1;
    mem_rdata = BLK_C;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    proc_addr = 30'h8;
    #1;
    chk("b2b_gap_mread", mem_read, 1'b0);
    chk("b2b_gap_stall", proc_stall, 1'b1);
    low = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      if (mem_read) break;
      low++;
    end
    chk("b2b_low_cycles", low, 1);
    chk("b2b_second_maddr", mem_addr, 28'h2);
    mem_ready = 1'b1;
    mem_rdata = BLK_D;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("b2b_second_stall", proc_stall, 1'b0);
    chk("b2b_second_rdata", proc_rdata, 32'hD0000001);
    tick();
    proc_addr = 30'h7;
    #1;
    chk("b2b_first_kept_stall", proc_stall, 1'b0);
    chk("b2b_first_kept_rdata", proc_rdata, 32'hC0000004);

    // Spurious mem_ready and writes while idle change nothing.
    tick();
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_wdata = 32'hFFFFFFFF;
    proc_addr  = 30'h30;
    mem_ready  = 1'b1;
    mem_rdata  = BLK_F;
    #1;
    chk("spur_stall",  proc_stall, 1'b0);
    chk("spur_mwrite", mem_write, 1'b0);
    chk("spur_mwdata", mem_wdata, 128'd0);
    tick();
    #1;
    chk("spur_mread2", mem_read, 1'b0);
    chk("spur_stall2", proc_stall, 1'b0);
    tick();
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    proc_write = 1'b0;
    proc_wdata = 32'h0;
    proc_read  = 1'b1;
    miss_seq("spur_after", 30'h30, 2, BLK_G);

    // Reset during refill: mem_read drops at once, late mem_ready ignored.
    tick();
    proc_addr = 30'h10;
    #1;
    chk("rmid_c0_stall", proc_stall, 1'b1);
    tick();
    #1;
    chk("rmid_mread_before", mem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_mread_drop", mem_read, 1'b0);
    proc_read = 1'b0;
    tick();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = BLK_E;
    #1;
    chk("rmid_late_ready_mread", mem_read, 1'b0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    proc_addr = 30'h0;
    proc_read = 1'b1;
    #1;
    chk("rmid_line0_cleared", proc_stall, 1'b1);
    proc_addr = 30'h10;
    miss_seq("rmid_after", 30'h10, 2, BLK_E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
